// File: rtl/pwm_capture.sv
// PWM receiver: recovers period and duty word from a synchronised input and flags a stuck line.
// Build option PWM_CAPTURE_FILTER_EN adds a FILTER_LEN-sample glitch filter after the synchroniser.

module pwm_capture #(
  parameter int DUTY_W  = 12,
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 8192
`ifdef PWM_CAPTURE_FILTER_EN
  ,
  parameter int FILTER_LEN = 3
`endif
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              valid,
  output logic              stuck,
  output logic              stuck_level
);

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DUTY_CAP  = CNT_W'((2 ** DUTY_W) - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              sInPrev_q;
  logic              sIn;
  logic              rise;
  logic [CNT_W-1:0]  periodCnt_q;
  logic [CNT_W-1:0]  highCnt_q;
  logic [CNT_W-1:0]  periodInc;
  logic [CNT_W-1:0]  highInc;
  logic [CNT_W-1:0]  highMinus1;
  logic [IDLE_W-1:0] idleCnt_q;
  logic [DUTY_W-1:0] duty_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sInPrev_q <= 1'b0;
    end else begin
      sync1_q   <= pwm_in;
      sync2_q   <= sync1_q;
      sInPrev_q <= sIn;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           filt_q;
  logic [FCW-1:0] filtCnt_q;

  // The filtered level flips only once the synchroniser has disagreed with it for FILTER_LEN samples in a row.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      filt_q    <= 1'b0;
      filtCnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      filtCnt_q <= '0;
    end else if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_q    <= sync2_q;
      filtCnt_q <= '0;
    end else begin
      filtCnt_q <= filtCnt_q + FCW'(1);
    end
  end

  assign sIn = filt_q;
`else
  assign sIn = sync2_q;
`endif

  assign rise       = sIn & ~sInPrev_q;
  assign periodInc  = (periodCnt_q == '1) ? periodCnt_q : periodCnt_q + CNT_ONE;
  assign highInc    = (highCnt_q == '1) ? highCnt_q : highCnt_q + CNT_ONE;
  assign highMinus1 = highCnt_q - CNT_ONE;
  assign duty_d     = (highMinus1 > DUTY_CAP) ? DUTY_CAP[DUTY_W-1:0] : highMinus1[DUTY_W-1:0];

  // A rise always beats a timeout landing on the same cycle, so the longest reportable period is TIMEOUT.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      periodCnt_q <= '0;
      highCnt_q   <= '0;
      idleCnt_q   <= '0;
      duty_out    <= '0;
      period_out  <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        idleCnt_q   <= '0;
        periodCnt_q <= CNT_ONE;
        highCnt_q   <= CNT_ONE;
        stuck       <= 1'b0;
        stuck_level <= 1'b0;
        state_q     <= ARMED;
        if (state_q == ARMED) begin
          period_out <= periodCnt_q;
          duty_out   <= duty_d;
          valid      <= 1'b1;
        end
      end else begin
        if (idleCnt_q != IDLE_SAT) begin
          idleCnt_q <= idleCnt_q + IDLE_ONE;
        end
        if (state_q == ARMED) begin
          periodCnt_q <= periodInc;
          if (sIn) begin
            highCnt_q <= highInc;
          end
        end
        if (idleCnt_q == IDLE_LAST) begin
          stuck       <= 1'b1;
          stuck_level <= sIn;
          state_q     <= IDLE;
        end else if (stuck) begin
          stuck_level <= sIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a cycle-indexed waveform model predicts valid/stuck events,
// and a negedge monitor pops and compares them as the DUT presents them.

module tb_pwm_capture;

  localparam int TIMEOUT    = 8192;
  localparam int PERIOD_MAX = 8191;
  localparam int DUTY_MAX   = 4095;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        pwm_in;
  logic [11:0] duty_out;
  logic [12:0] period_out;
  logic        valid;
  logic        stuck;
  logic        stuck_level;

  pwm_capture dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int {EV_VALID, EV_STUCK, EV_CLEAR} evKind_t;
  typedef struct {
    evKind_t kind;
    int      period;
    int      duty;
    int      level;
  } expEvent_t;

  expEvent_t expQ[$];
  expEvent_t monEv;

  int nChecks    = 0;
  int nErrors    = 0;
  int prefix[$];
  bit armed      = 1'b0;
  bit mStuck     = 1'b0;
  bit prevLvl    = 1'b0;
  int lastRise   = 0;
  bit monOn      = 1'b0;
  bit prevStuck  = 1'b0;
  int holdPeriod = 0;
  int holdDuty   = 0;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    armed    = 1'b0;
    mStuck   = 1'b0;
    prevLvl  = 1'b0;
    lastRise = prefix.size() - 1;
  endtask

  // prefix[c] holds the number of high cycles before input cycle c, so any high time is a difference.
  task automatic modelStep(input bit lvl);
    int        c = prefix.size() - 1;
    expEvent_t e;
    if (lvl && !prevLvl) begin
      if (mStuck) begin
        e = '{kind: EV_CLEAR, period: 0, duty: 0, level: 0};
        expQ.push_back(e);
      end else if (armed) begin
        e = '{kind: EV_VALID, period: minInt(c - lastRise, PERIOD_MAX),
              duty: minInt(prefix[c] - prefix[lastRise] - 1, DUTY_MAX), level: 0};
        expQ.push_back(e);
      end
      armed    = 1'b1;
      mStuck   = 1'b0;
      lastRise = c;
    end else if (!mStuck && (c - lastRise) == TIMEOUT) begin
      mStuck = 1'b1;
      armed  = 1'b0;
      e = '{kind: EV_STUCK, period: 0, duty: 0, level: int'(lvl)};
      expQ.push_back(e);
    end
    prefix.push_back(prefix[c] + int'(lvl));
    prevLvl = lvl;
  endtask

  task automatic applyRaw(input bit driveLvl, input bit modelLvl, input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      pwm_in = driveLvl;
      modelStep(modelLvl);
    end
  endtask

  task automatic applyStimulus(input bit lvl, input int n);
    applyRaw(lvl, lvl, n);
  endtask

  task automatic applyPwm(input int period, input int high, input int count);
    repeat (count) begin
      applyStimulus(1'b1, high);
      applyStimulus(1'b0, period - high);
    end
  endtask

  task automatic applyReset(input int n);
    @(posedge clk_in);
    #1;
    checkOutput("queue empty before reset", expQ.size(), 0);
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    monOn   = 1'b0;
    repeat (n) begin
      @(negedge clk_in);
      checkOutput("reset duty_out", int'(duty_out), 0);
      checkOutput("reset period_out", int'(period_out), 0);
      checkOutput("reset valid", int'(valid), 0);
      checkOutput("reset stuck", int'(stuck), 0);
      checkOutput("reset stuck_level", int'(stuck_level), 0);
    end
    @(posedge clk_in);
    #1;
    reset_n    = 1'b1;
    holdPeriod = 0;
    holdDuty   = 0;
    modelReset();
    monOn      = 1'b1;
  endtask

  // Monitor: every DUT event must match the head of the expected queue; outputs must hold between valids.
  always @(negedge clk_in) begin
    if (!reset_n) begin
      prevStuck = 1'b0;
    end else if (monOn) begin
      if (valid) begin
        if (expQ.size() != 0 && expQ[0].kind == EV_VALID) begin
          monEv = expQ.pop_front();
          checkOutput("period_out", int'(period_out), monEv.period);
          checkOutput("duty_out", int'(duty_out), monEv.duty);
          holdPeriod = monEv.period;
          holdDuty   = monEv.duty;
        end else begin
          checkOutput("unexpected valid", int'(valid), 0);
        end
      end else begin
        checkOutput("period_out hold", int'(period_out), holdPeriod);
        checkOutput("duty_out hold", int'(duty_out), holdDuty);
      end
      if (stuck && !prevStuck) begin
        if (expQ.size() != 0 && expQ[0].kind == EV_STUCK) begin
          monEv = expQ.pop_front();
          checkOutput("stuck_level", int'(stuck_level), monEv.level);
        end else begin
          checkOutput("unexpected stuck", int'(stuck), 0);
        end
      end
      if (!stuck && prevStuck) begin
        if (expQ.size() != 0 && expQ[0].kind == EV_CLEAR) begin
          monEv = expQ.pop_front();
          checkOutput("stuck clear", int'(stuck), 0);
        end else begin
          checkOutput("unexpected stuck clear", int'(stuck), 1);
        end
      end
      prevStuck = stuck;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run still active at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p;
    int h;
    int waitCyc;
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    prefix.push_back(0);
    modelReset();
    applyReset(3);

    $display("[TB] generator-style 4096/2048");
    applyPwm(4096, 2048, 2);
`ifndef PWM_CAPTURE_FILTER_EN
    applyPwm(4096, 1, 1);
`endif
    applyPwm(4096, 4095, 1);

    $display("[TB] constant high, then restart");
    applyStimulus(1'b1, 10000);
    applyStimulus(1'b0, 10);
    applyPwm(1000, 250, 3);

    $display("[TB] reset mid-period");
    applyPwm(1000, 250, 1);
    applyStimulus(1'b1, 250);
    applyStimulus(1'b0, 250);
    applyReset(5);
    applyPwm(1000, 250, 3);

    $display("[TB] period change 4096 -> 1000");
    applyPwm(4096, 2048, 1);
    applyPwm(1000, 250, 3);

`ifdef PWM_CAPTURE_FILTER_EN
    $display("[TB] glitch filter");
    repeat (2) begin
      applyStimulus(1'b1, 500);
      applyStimulus(1'b0, 200);
      applyRaw(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 298);
    end
    applyStimulus(1'b1, 500);
    applyStimulus(1'b0, 200);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 297);
`endif

    $display("[TB] random periods");
    repeat (6) begin
      p = int'($urandom_range(1500, 20));
      h = int'($urandom_range(p - 4, 4));
      applyPwm(p, h, 1);
    end

    $display("[TB] timeout boundary and duty saturation");
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 8092);
    applyStimulus(1'b1, 4097);
    applyStimulus(1'b0, 903);
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 8093);
    applyPwm(1000, 250, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 20);

    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 50) begin
      @(negedge clk_in);
      waitCyc++;
    end
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
